// File: rtl/param_priority_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// param_priority_arbiter_pkg
// Shared definitions for the display-pipeline request arbiter.
//   ARB_FIXED / ARB_RR : encodings of the rr_en mode input
//   clog2()            : ceiling log2, used to size winner indices
// -----------------------------------------------------------------------------
package param_priority_arbiter_pkg;

    localparam logic ARB_FIXED = 1'b0;  // highest pending index wins
    localparam logic ARB_RR    = 1'b1;  // rotating priority behind the last winner

    // Ceiling log2 of value; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits++;
            rem = rem >> 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/param_priority_arbiter_encoder.sv
// -----------------------------------------------------------------------------
// priority_encoder_n
// Combinational highest-index-wins encoder.
//   vec : request vector
//   num : index of the highest set bit (0 when vec is empty)
//   any : at least one bit of vec is set
// -----------------------------------------------------------------------------
module priority_encoder_n
    import param_priority_arbiter_pkg::*;
#(
    parameter  int N     = 8,
    localparam int IDX_W = (N > 1) ? clog2(N) : 1
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] num,
    output logic             any
);

    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        num = '0;
        any = 1'b0;
        // Ascending scan: a later (higher) set bit overrides an earlier one.
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                num = IDX_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/param_priority_arbiter.sv
// -----------------------------------------------------------------------------
// param_priority_arbiter
// Registered N-channel request arbiter. Single-cycle request pulses collect in
// a pending set; one winner per load is presented on a valid/ready output.
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   req_i       : per-channel request pulses
//   rr_en       : ARB_FIXED = highest index wins, ARB_RR = round-robin
//   out_valid   : winner register holds an unconsumed grant
//   out_ready   : consumer takes the grant when high with out_valid
//   out_num     : index of the granted channel
//   out_onehot  : one-hot of out_num, zero while out_valid is low
//   any         : a grant is presented or requests are pending
//   lost        : one-cycle pulse, a request hit an already pending channel
// -----------------------------------------------------------------------------
module param_priority_arbiter
    import param_priority_arbiter_pkg::*;
#(
    parameter  int N     = 8,
    localparam int IDX_W = (N > 1) ? clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_i,
    input  logic             rr_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_num,
    output logic [N-1:0]     out_onehot,
    output logic             any,
    output logic             lost
);

    logic [N-1:0]     pending;
    logic [IDX_W-1:0] ptr;       // last winner; lowest round-robin priority

    logic             use_rr;
    logic [N-1:0]     rot;
    logic [N-1:0]     enc_in;
    logic [IDX_W-1:0] enc_num;
    logic             enc_any;
    logic [IDX_W:0]   rr_sum;
    logic [IDX_W-1:0] winner;
    logic [N-1:0]     win_oh;
    logic [N-1:0]     clr;
    logic             load;

    assign use_rr = (rr_en == ARB_RR);

    // rot[j] = pending[(ptr + j) mod N]: the top bit of rot is channel ptr-1,
    // so a highest-index encoder searches ptr-1, ptr-2, ... and ends at ptr.
    assign rot    = N'({pending, pending} >> ptr);
    assign enc_in = use_rr ? rot : pending;

    priority_encoder_n #(.N(N)) u_enc (
        .vec (enc_in),
        .num (enc_num),
        .any (enc_any)
    );

    // De-rotate: winner = (enc_num + ptr) mod N. Both terms are < N, so a
    // single conditional subtract suffices, also for non-power-of-two N.
    assign rr_sum = {1'b0, enc_num} + {1'b0, ptr};

    always_comb begin
        winner = enc_num;
        if (use_rr) begin
            if (rr_sum >= (IDX_W+1)'(N)) begin
                winner = IDX_W'(rr_sum - (IDX_W+1)'(N));
            end else begin
                winner = rr_sum[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        win_oh = '0;
        for (int i = 0; i < N; i++) begin
            win_oh[i] = (winner == IDX_W'(i));
        end
    end

    // Output register is free when empty or being consumed this cycle, which
    // gives back-to-back grants with no bubble.
    assign load = enc_any & (~out_valid | out_ready);
    assign clr  = load ? win_oh : '0;
    assign any  = out_valid | (|pending);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= '0;
            ptr        <= '0;
            out_valid  <= 1'b0;
            out_num    <= '0;
            out_onehot <= '0;
            lost       <= 1'b0;
        end else begin
            // A request on the winner's own channel in its load cycle re-arms
            // the bit as a fresh request instead of counting as lost.
            pending <= (pending & ~clr) | req_i;
            lost    <= |(req_i & pending & ~clr);
            if (load) begin
                out_valid  <= 1'b1;
                out_num    <= winner;
                out_onehot <= win_oh;
                ptr        <= winner;
            end else if (out_valid && out_ready) begin
                out_valid  <= 1'b0;
                out_onehot <= '0;
            end
        end
    end

endmodule

// File: tb/tb_param_priority_arbiter.sv
module tb_param_priority_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req_i;
    logic       rr_en;
    logic       out_ready;
    logic       out_valid;
    logic [2:0] out_num;
    logic [7:0] out_onehot;
    logic       any;
    logic       lost;

    logic       req1;
    logic       rr1 = 1'b1;
    logic       ready1;
    logic       valid1;
    logic [0:0] num1;
    logic [0:0] oh1;
    logic       any1;
    logic       lost1;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    param_priority_arbiter #(.N(8)) dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req_i),
        .rr_en      (rr_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_num    (out_num),
        .out_onehot (out_onehot),
        .any        (any),
        .lost       (lost)
    );

    param_priority_arbiter #(.N(1)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req1),
        .rr_en      (rr1),
        .out_valid  (valid1),
        .out_ready  (ready1),
        .out_num    (num1),
        .out_onehot (oh1),
        .any        (any1),
        .lost       (lost1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (N = 8) ----------------
    bit [7:0] m_pend  = '0;
    bit       m_valid = 1'b0;
    bit       m_lost  = 1'b0;
    int       m_num   = 0;
    int       m_ptr   = 0;
    int       m_w;
    logic [7:0] m_clr;

    // Fixed: highest pending index. Round-robin: walk down from ptr-1,
    // wrapping, ending at ptr itself.
    function automatic int pick(input bit [7:0] p, input logic rr, input int ptr);
        if (!rr) begin
            for (int i = 7; i >= 0; i--) if (p[i]) return i;
        end else begin
            for (int k = 1; k <= 8; k++) begin
                int c;
                c = (ptr + 8 - k) % 8;
                if (p[c]) return c;
            end
        end
        return -1;
    endfunction

    assign m_w   = (m_pend != 0 && (!m_valid || out_ready)) ? pick(m_pend, rr_en, m_ptr) : -1;
    assign m_clr = (m_w >= 0) ? (8'b1 << m_w) : 8'h00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend  <= '0;
            m_valid <= 1'b0;
            m_lost  <= 1'b0;
            m_num   <= 0;
            m_ptr   <= 0;
        end else begin
            m_lost <= |(req_i & m_pend & ~m_clr);
            m_pend <= (m_pend & ~m_clr) | req_i;
            if (m_w >= 0) begin
                m_valid <= 1'b1;
                m_num   <= m_w;
                m_ptr   <= m_w;
            end else if (m_valid && out_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            check("m_valid",  out_valid,  m_valid);
            check("m_num",    out_num,    m_num);
            check("m_onehot", out_onehot, m_valid ? (8'b1 << m_num) : 8'h00);
            check("m_any",    any,        m_valid || (m_pend != 0));
            check("m_lost",   lost,       m_lost);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic apply_reset();
        rst_n     = 1'b0;
        req_i     = '0;
        req1      = 1'b0;
        out_ready = 1'b0;
        ready1    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] v);
        req_i = v;
        @(posedge clk);
        #1;
        req_i = '0;
    endtask

    task automatic rr_run(input logic mode, input int exp_seq[6]);
        int got[$];
        int budget;
        apply_reset();
        rr_en     = mode;
        out_ready = 1'b1;
        drive(8'h24);
        budget = 0;
        // Re-request the channel that is about to be loaded, in its load cycle.
        while (got.size() < 6 && budget < 30) begin
            @(negedge clk);
            budget++;
            if (out_valid) got.push_back(int'(out_num));
            req_i = (got.size() < 6 && m_w >= 0) ? m_clr : 8'h00;
        end
        req_i = '0;
        check($sformatf("rr%0d_count", mode), got.size(), 6);
        for (int k = 0; k < got.size() && k < 6; k++) begin
            check($sformatf("rr%0d_grant%0d", mode, k), got[k], exp_seq[k]);
        end
        budget = 0;
        while (any && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check($sformatf("rr%0d_drain", mode), any, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         fx_num_t[3];
        logic [7:0] fx_oh_t[3];
        fx_num_t = '{7, 4, 1};
        fx_oh_t  = '{8'h80, 8'h10, 8'h02};

        rst_n = 1'b0; req_i = '0; rr_en = 1'b0; out_ready = 1'b0;
        req1 = 1'b0; ready1 = 1'b0;
        apply_reset();
        cmp_en = 1'b1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_any",   any,       1'b0);
        check("rst_num",   out_num,   3'd0);

        // Fixed priority drains 7, 4, 1 back to back.
        rr_en = 1'b0; out_ready = 1'b1;
        drive(8'b1001_0010);
        @(negedge clk);
        check("fx_latency", out_valid, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("fx_valid%0d", k), out_valid,  1'b1);
            check($sformatf("fx_num%0d", k),   out_num,    fx_num_t[k]);
            check($sformatf("fx_oh%0d", k),    out_onehot, fx_oh_t[k]);
        end
        @(negedge clk);
        check("fx_done_valid", out_valid, 1'b0);
        check("fx_done_any",   any,       1'b0);

        // Backpressure holds channel 0; channel 6 follows once accepted.
        apply_reset();
        drive(8'h01);
        drive(8'h40);
        repeat (3) begin
            @(negedge clk);
            check("bp_valid", out_valid,  1'b1);
            check("bp_num",   out_num,    3'd0);
            check("bp_oh",    out_onehot, 8'h01);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_next_valid", out_valid, 1'b1);
        check("bp_next_num",   out_num,   3'd6);
        @(negedge clk);
        check("bp_end_valid", out_valid, 1'b0);

        // Round-robin alternates; fixed starves channel 2.
        rr_run(1'b1, '{5, 2, 5, 2, 5, 2});
        rr_run(1'b0, '{5, 5, 5, 5, 5, 5});

        // Lost / merge on channel 3.
        apply_reset();
        rr_en = 1'b0;
        req_i = 8'h08;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("ls_loadcycle_lost", lost,    1'b0);
        check("ls_first_num",      out_num, 3'd3);
        @(posedge clk); #1;
        req_i = '0;
        @(negedge clk);
        check("ls_pulse", lost,      1'b1);
        check("ls_held",  out_valid, 1'b1);
        @(negedge clk);
        check("ls_once", lost, 1'b0);
        check("ls_any",  any,  1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        check("ls_second_valid", out_valid,  1'b1);
        check("ls_second_num",   out_num,    3'd3);
        check("ls_second_oh",    out_onehot, 8'h08);
        @(negedge clk);
        check("ls_end_valid", out_valid, 1'b0);
        check("ls_end_any",   any,       1'b0);

        // Reset in the middle of a presented grant with pending = A5.
        apply_reset();
        req_i = 8'hA5;
        @(posedge clk); #1;
        @(posedge clk); #1;
        req_i = '0;
        check("rs_pre_valid", out_valid, 1'b1);
        check("rs_pre_num",   out_num,   3'd7);
        #1;
        rst_n = 1'b0;
        #1;
        check("rs_valid", out_valid,  1'b0);
        check("rs_num",   out_num,    3'd0);
        check("rs_oh",    out_onehot, 8'h00);
        check("rs_any",   any,        1'b0);
        check("rs_lost",  lost,       1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("rs_after_valid", out_valid, 1'b0);
            check("rs_after_any",   any,       1'b0);
            check("rs_after_lost",  lost,      1'b0);
        end

        // N = 1 instance.
        apply_reset();
        req1 = 1'b1;
        @(posedge clk); #1;
        req1 = 1'b0;
        @(negedge clk);
        check("n1_pend_valid", valid1, 1'b0);
        check("n1_pend_any",   any1,   1'b1);
        repeat (3) begin
            @(negedge clk);
            check("n1_valid", valid1, 1'b1);
            check("n1_num",   num1,   1'b0);
            check("n1_oh",    oh1,    1'b1);
            check("n1_any",   any1,   1'b1);
        end
        ready1 = 1'b1;
        @(negedge clk);
        check("n1_done_valid", valid1, 1'b0);
        check("n1_done_oh",    oh1,    1'b0);
        check("n1_done_any",   any1,   1'b0);
        check("n1_lost",       lost1,  1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
